// File: rtl/atm_session_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : atm_session_initiator_pkg
// Description : Shared encodings for the ATM session initiator. This file
//               holds the ATM operation codes, the ATM state codes, the
//               host response status codes and the initiator FSM states.
//               It also provides a helper that recognises legal host
//               transaction operations.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package atm_session_initiator_pkg;

  // Operation codes driven onto the ATM operation input
  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_AUTH     = 3'd1;
  localparam logic [2:0] OP_BALANCE  = 3'd2;
  localparam logic [2:0] OP_WITHDRAW = 3'd3;
  localparam logic [2:0] OP_DEPOSIT  = 3'd4;
  localparam logic [2:0] OP_EXIT     = 3'd5;

  // State codes reported by the ATM
  localparam logic [2:0] A_IDLE      = 3'd0;
  localparam logic [2:0] A_BUSY      = 3'd1;
  localparam logic [2:0] A_AUTH_OK   = 3'd2;
  localparam logic [2:0] A_AUTH_FAIL = 3'd3;
  localparam logic [2:0] A_DONE      = 3'd4;
  localparam logic [2:0] A_DENIED    = 3'd5;

  // Status codes returned to the host
  localparam logic [2:0] ST_OK        = 3'd0;
  localparam logic [2:0] ST_AUTH_FAIL = 3'd1;
  localparam logic [2:0] ST_INSUFF    = 3'd2;
  localparam logic [2:0] ST_LOCKED    = 3'd3;
  localparam logic [2:0] ST_BAD_ACC   = 3'd4;
  localparam logic [2:0] ST_TIMEOUT   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_AUTH  = 3'd2,
    S_TXN   = 3'd3,
    S_EXIT  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  // Only these three operations may be requested by the host
  function automatic logic is_txn_op(input logic [2:0] op);
    return (op == OP_BALANCE) || (op == OP_WITHDRAW) || (op == OP_DEPOSIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/atm_session_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : atm_session_initiator_if
// Description : Bundles the host request/response handshake and the ATM
//               transaction bus.
//               slave  : the initiator's view. It receives requests and ATM
//                        state, and drives responses and ATM commands.
//               master : the host/ATM environment's view.
// Ports       : req_valid/ready/op/acc/pin/amount, rsp_valid/ready/status/
//               balance, atm_operation/acc_num/pin/amount, atm_balance/state
// Revision    : 1.0 - initial release
// ============================================================================
interface atm_session_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [3:0]  req_acc;
  logic [15:0] req_pin;
  logic [15:0] req_amount;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_status;
  logic [15:0] rsp_balance;

  logic [2:0]  atm_operation;
  logic [3:0]  atm_acc_num;
  logic [15:0] atm_pin;
  logic [15:0] atm_amount;
  logic [15:0] atm_balance;
  logic [2:0]  atm_state;

  modport slave (
    input  req_valid, req_op, req_acc, req_pin, req_amount, rsp_ready,
           atm_balance, atm_state,
    output req_ready, rsp_valid, rsp_status, rsp_balance,
           atm_operation, atm_acc_num, atm_pin, atm_amount
  );

  modport master (
    output req_valid, req_op, req_acc, req_pin, req_amount, rsp_ready,
           atm_balance, atm_state,
    input  req_ready, rsp_valid, rsp_status, rsp_balance,
           atm_operation, atm_acc_num, atm_pin, atm_amount
  );
endinterface
`default_nettype wire

// File: rtl/atm_session_initiator_fail_tracker.sv
`default_nettype none
// ============================================================================
// Module      : atm_fail_tracker
// Description : Keeps one saturating counter of consecutive authentication
//               failures for each account. An account is locked once its
//               counter reaches MAX_FAILS. Only reset clears a lock.
// Ports       : clk, rst_n (sync, active-low)
//               inc    - count one failure for account acc
//               clr    - clear the counter for account acc
//               acc    - account selector
//               locked - selected account is locked (0 for out-of-range acc)
// Revision    : 1.0 - initial release
// ============================================================================
module atm_fail_tracker #(
  parameter int NUM_ACCOUNTS = 10,
  parameter int MAX_FAILS    = 3,
  parameter int ACC_W        = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             inc,
  input  wire logic             clr,
  input  wire logic [ACC_W-1:0] acc,
  output logic                  locked
);

  localparam int CNT_W = (MAX_FAILS < 2) ? 1 : $clog2(MAX_FAILS + 1);

  logic [NUM_ACCOUNTS-1:0] w_hit;

  for (genvar i = 0; i < NUM_ACCOUNTS; i++) begin : g_cnt
    logic             w_sel;
    logic [CNT_W-1:0] r_cnt;

    assign w_sel    = (acc == ACC_W'(i));
    assign w_hit[i] = w_sel && (r_cnt == CNT_W'(MAX_FAILS));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_sel && clr) begin
        r_cnt <= '0;
      end else if (w_sel && inc && (r_cnt != CNT_W'(MAX_FAILS))) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign locked = |w_hit;

endmodule
`default_nettype wire

// File: rtl/atm_session_initiator.sv
`default_nettype none
// ============================================================================
// Module      : atm_session_initiator
// Description : Host-side initiator for the ATM core. It accepts one request
//               and runs authenticate -> transact -> exit on the ATM bus. It
//               then returns a single status and balance to the host. Bad
//               account numbers and illegal operations are filtered out. A
//               response timeout applies to each ATM phase, and an account is
//               locked after repeated PIN failures.
// Ports       : clk, rst_n (sync, active-low)
//               bus (slave modport): request handshake, response handshake,
//               ATM command outputs and ATM state/balance inputs
// Revision    : 1.0 - initial release
// ============================================================================
module atm_session_initiator
  import atm_session_initiator_pkg::*;
#(
  parameter int NUM_ACCOUNTS   = 10,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_FAILS      = 3
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  atm_session_initiator_if.slave bus
);

  localparam int ACC_W   = 4;
  localparam int TIMER_W = ($clog2(TIMEOUT_CYCLES + 1) > 7) ? $clog2(TIMEOUT_CYCLES + 1) : 7;
  localparam logic [TIMER_W-1:0] C_TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state, w_state_d;
  logic [2:0]         r_op, w_op_d;
  logic [ACC_W-1:0]   r_acc, w_acc_d;
  logic [15:0]        r_pin, w_pin_d;
  logic [15:0]        r_amount, w_amount_d;
  logic [TIMER_W-1:0] r_timer, w_timer_d;
  logic [2:0]         r_atm_op, w_atm_op_d;
  logic [ACC_W-1:0]   r_atm_acc, w_atm_acc_d;
  logic [15:0]        r_atm_pin, w_atm_pin_d;
  logic [15:0]        r_atm_amount, w_atm_amount_d;
  logic               r_rsp_valid, w_rsp_valid_d;
  logic [2:0]         r_rsp_status, w_rsp_status_d;
  logic [15:0]        r_rsp_balance, w_rsp_balance_d;
  logic               w_inc, w_clr, w_locked;
  logic               w_acc_bad;
  logic               w_first;

  atm_fail_tracker #(
    .NUM_ACCOUNTS (NUM_ACCOUNTS),
    .MAX_FAILS    (MAX_FAILS),
    .ACC_W        (ACC_W)
  ) u_fail_tracker (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (w_inc),
    .clr    (w_clr),
    .acc    (r_acc),
    .locked (w_locked)
  );

  assign w_acc_bad = (int'(r_acc) >= NUM_ACCOUNTS);
  // The ATM still shows its previous state on the first cycle of a phase.
  assign w_first   = (r_timer == '0);

  assign bus.req_ready     = (r_state == S_IDLE);
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_status    = r_rsp_status;
  assign bus.rsp_balance   = r_rsp_balance;
  assign bus.atm_operation = r_atm_op;
  assign bus.atm_acc_num   = r_atm_acc;
  assign bus.atm_pin       = r_atm_pin;
  assign bus.atm_amount    = r_atm_amount;

  always_comb begin
    w_state_d       = r_state;
    w_op_d          = r_op;
    w_acc_d         = r_acc;
    w_pin_d         = r_pin;
    w_amount_d      = r_amount;
    w_timer_d       = r_timer;
    w_atm_op_d      = r_atm_op;
    w_atm_acc_d     = r_atm_acc;
    w_atm_pin_d     = r_atm_pin;
    w_atm_amount_d  = r_atm_amount;
    w_rsp_valid_d   = r_rsp_valid;
    w_rsp_status_d  = r_rsp_status;
    w_rsp_balance_d = r_rsp_balance;
    w_inc           = 1'b0;
    w_clr           = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_op_d          = bus.req_op;
          w_acc_d         = bus.req_acc;
          w_pin_d         = bus.req_pin;
          w_amount_d      = bus.req_amount;
          w_rsp_status_d  = ST_OK;
          w_rsp_balance_d = '0;
          w_state_d       = S_CHECK;
        end
      end

      S_CHECK: begin
        if (w_acc_bad || w_locked || !is_txn_op(r_op)) begin
          // Requests that fail here never reach the ATM.
          w_state_d       = S_RESP;
          w_rsp_valid_d   = 1'b1;
          w_rsp_balance_d = '0;
          w_rsp_status_d  = (!w_acc_bad && w_locked) ? ST_LOCKED : ST_BAD_ACC;
        end else begin
          w_state_d   = S_AUTH;
          w_atm_op_d  = OP_AUTH;
          w_atm_acc_d = r_acc;
          w_atm_pin_d = r_pin;
          w_timer_d   = '0;
        end
      end

      S_AUTH: begin
        // A valid response has priority over a timeout in the same cycle.
        if (!w_first && (bus.atm_state == A_AUTH_OK)) begin
          w_clr          = 1'b1;
          w_state_d      = S_TXN;
          w_atm_op_d     = r_op;
          w_atm_amount_d = r_amount;
          w_timer_d      = '0;
        end else if (!w_first && (bus.atm_state == A_AUTH_FAIL)) begin
          w_inc           = 1'b1;
          w_state_d       = S_EXIT;
          w_atm_op_d      = OP_EXIT;
          w_rsp_status_d  = ST_AUTH_FAIL;
          w_rsp_balance_d = '0;
        end else if (r_timer == C_TIMER_LAST) begin
          w_state_d       = S_EXIT;
          w_atm_op_d      = OP_EXIT;
          w_rsp_status_d  = ST_TIMEOUT;
          w_rsp_balance_d = '0;
        end else begin
          w_timer_d = r_timer + TIMER_W'(1);
        end
      end

      S_TXN: begin
        if (!w_first && (bus.atm_state == A_DONE)) begin
          w_state_d       = S_EXIT;
          w_atm_op_d      = OP_EXIT;
          w_rsp_status_d  = ST_OK;
          w_rsp_balance_d = bus.atm_balance;
        end else if (!w_first && (bus.atm_state == A_DENIED)) begin
          w_state_d       = S_EXIT;
          w_atm_op_d      = OP_EXIT;
          w_rsp_status_d  = ST_INSUFF;
          w_rsp_balance_d = bus.atm_balance;
        end else if (r_timer == C_TIMER_LAST) begin
          w_state_d       = S_EXIT;
          w_atm_op_d      = OP_EXIT;
          w_rsp_status_d  = ST_TIMEOUT;
          w_rsp_balance_d = '0;
        end else begin
          w_timer_d = r_timer + TIMER_W'(1);
        end
      end

      S_EXIT: begin
        w_state_d     = S_RESP;
        w_atm_op_d    = OP_NOP;
        w_rsp_valid_d = 1'b1;
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid_d = 1'b0;
          w_state_d     = S_IDLE;
        end
      end

      default: begin
        w_state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_op          <= OP_NOP;
      r_acc         <= '0;
      r_pin         <= '0;
      r_amount      <= '0;
      r_timer       <= '0;
      r_atm_op      <= OP_NOP;
      r_atm_acc     <= '0;
      r_atm_pin     <= '0;
      r_atm_amount  <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_status  <= ST_OK;
      r_rsp_balance <= '0;
    end else begin
      r_state       <= w_state_d;
      r_op          <= w_op_d;
      r_acc         <= w_acc_d;
      r_pin         <= w_pin_d;
      r_amount      <= w_amount_d;
      r_timer       <= w_timer_d;
      r_atm_op      <= w_atm_op_d;
      r_atm_acc     <= w_atm_acc_d;
      r_atm_pin     <= w_atm_pin_d;
      r_atm_amount  <= w_atm_amount_d;
      r_rsp_valid   <= w_rsp_valid_d;
      r_rsp_status  <= w_rsp_status_d;
      r_rsp_balance <= w_rsp_balance_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_atm_session_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_atm_session_initiator
// Description : Self-checking bench for atm_session_initiator. A behavioural
//               ATM answers the bus. A reference model predicts each
//               response's status, balance and latency from the account
//               rules.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_atm_session_initiator;
  import atm_session_initiator_pkg::*;

  localparam int NACC = 10;
  localparam int TMO  = 64;
  localparam int MAXF = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  atm_session_initiator_if bus ();

  atm_session_initiator #(
    .NUM_ACCOUNTS   (NACC),
    .TIMEOUT_CYCLES (TMO),
    .MAX_FAILS      (MAXF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pin_of(input logic [3:0] a);
    return 16'h1000 + {12'd0, a} * 16'd37;
  endfunction

  // Behavioural ATM environment
  logic [15:0] atm_bal [16];
  int          d_auth, d_txn;
  bit          hang_auth, hang_txn;

  // Reference model state
  logic [15:0] m_bal  [16];
  int          m_fail [16];

  task automatic atm_respond(input logic [2:0] op);
    logic [3:0] a;
    a = bus.atm_acc_num;
    case (op)
      OP_AUTH:    bus.atm_state = (bus.atm_pin == pin_of(a)) ? A_AUTH_OK : A_AUTH_FAIL;
      OP_BALANCE: begin bus.atm_state = A_DONE; bus.atm_balance = atm_bal[a]; end
      OP_WITHDRAW: begin
        if (bus.atm_amount > atm_bal[a]) bus.atm_state = A_DENIED;
        else begin atm_bal[a] = atm_bal[a] - bus.atm_amount; bus.atm_state = A_DONE; end
        bus.atm_balance = atm_bal[a];
      end
      OP_DEPOSIT: begin
        atm_bal[a] = atm_bal[a] + bus.atm_amount;
        bus.atm_state = A_DONE;
        bus.atm_balance = atm_bal[a];
      end
      default: bus.atm_state = A_IDLE;
    endcase
  endtask

  initial begin : atm_env
    logic [2:0] prev;
    bit pend, hang;
    int cnt;
    prev = OP_NOP; pend = 0; hang = 0; cnt = 0;
    bus.atm_state = A_IDLE;
    bus.atm_balance = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = OP_NOP; pend = 0; bus.atm_state = A_IDLE;
      end else begin
        if (bus.atm_operation != prev) begin
          prev = bus.atm_operation;
          pend = 0;
          if (prev == OP_AUTH) begin
            pend = 1; cnt = d_auth; hang = hang_auth;
          end else if (prev inside {OP_BALANCE, OP_WITHDRAW, OP_DEPOSIT}) begin
            pend = 1; cnt = d_txn; hang = hang_txn;
          end else begin
            bus.atm_state = A_IDLE;
          end
        end
        if (pend) begin
          if (hang || cnt > 0) begin
            bus.atm_state = A_BUSY;
            if (!hang) cnt--;
          end else begin
            atm_respond(prev);
            pend = 0;
          end
        end
      end
    end
  end

  // Predicts the outcome of one request from the account rules.
  // Latency counts cycles from the acceptance edge to the cycle in which
  // rsp_valid is first seen: CHECK, AUTH phase, TXN phase, EXIT, RESP. A
  // phase lasts at least 2 cycles because the ATM's first-cycle state is
  // ignored.
  task automatic model_predict(input logic [2:0] op, input logic [3:0] acc,
                               input logic [15:0] pin, input logic [15:0] amt,
                               input int da, input int dt, input bit ha, input bit ht,
                               output logic [2:0] st, output logic [15:0] bal,
                               output int lat, output bit reaches);
    int a_len, t_len;
    bit a_to, t_to;
    st = ST_OK; bal = '0; lat = 2; reaches = 0;
    if (int'(acc) >= NACC) st = ST_BAD_ACC;
    else if (m_fail[acc] == MAXF) st = ST_LOCKED;
    else if (!(op inside {OP_BALANCE, OP_WITHDRAW, OP_DEPOSIT})) st = ST_BAD_ACC;
    else begin
      reaches = 1;
      a_to  = ha || (da + 1 > TMO);
      a_len = a_to ? TMO : ((da + 1 > 2) ? da + 1 : 2);
      if (a_to) begin
        st = ST_TIMEOUT; lat = 3 + a_len;
      end else if (pin != pin_of(acc)) begin
        st = ST_AUTH_FAIL; lat = 3 + a_len;
        if (m_fail[acc] < MAXF) m_fail[acc]++;
      end else begin
        m_fail[acc] = 0;
        t_to  = ht || (dt + 1 > TMO);
        t_len = t_to ? TMO : ((dt + 1 > 2) ? dt + 1 : 2);
        lat   = 3 + a_len + t_len;
        if (t_to) st = ST_TIMEOUT;
        else if (op == OP_BALANCE) bal = m_bal[acc];
        else if (op == OP_WITHDRAW) begin
          if (amt > m_bal[acc]) st = ST_INSUFF;
          else m_bal[acc] = m_bal[acc] - amt;
          bal = m_bal[acc];
        end else begin
          m_bal[acc] = m_bal[acc] + amt;
          bal = m_bal[acc];
        end
      end
    end
  endtask

  task automatic run_txn(input string tag, input logic [2:0] op, input logic [3:0] acc,
                         input logic [15:0] pin, input logic [15:0] amt,
                         input int da, input int dt, input bit ha, input bit ht, input int hold);
    logic [2:0]  e_st;
    logic [15:0] e_bal;
    int          e_lat, cyc, w, n_exit, n_auth, n_act;
    bit          reaches;
    model_predict(op, acc, pin, amt, da, dt, ha, ht, e_st, e_bal, e_lat, reaches);
    d_auth = da; d_txn = dt; hang_auth = ha; hang_txn = ht;
    w = 0;
    while (!bus.req_ready && w < 20) begin @(posedge clk); #1; w++; end
    if (!bus.req_ready) begin
      check_eq({tag, "_req_ready_wait"}, 32'd0, 32'd1);
      return;
    end
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_acc = acc;
    bus.req_pin = pin; bus.req_amount = amt;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'($urandom);
    bus.req_acc    = 4'($urandom);
    bus.req_pin    = 16'($urandom);
    bus.req_amount = 16'($urandom);
    cyc = 1; n_exit = 0; n_auth = 0; n_act = 0;
    while (!bus.rsp_valid && cyc < 400) begin
      if (bus.atm_operation == OP_EXIT) n_exit++;
      if (bus.atm_operation == OP_AUTH) n_auth++;
      if (bus.atm_operation != OP_NOP) n_act++;
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, "_latency"}, cyc, e_lat);
    check_eq({tag, "_status"}, 32'(bus.rsp_status), 32'(e_st));
    check_eq({tag, "_balance"}, 32'(bus.rsp_balance), 32'(e_bal));
    check_eq({tag, "_resp_op_nop"}, 32'(bus.atm_operation), 32'(OP_NOP));
    if (reaches) begin
      check_eq({tag, "_exit_cycles"}, n_exit, 1);
      check_eq({tag, "_auth_seen"}, 32'(n_auth != 0), 32'd1);
    end else begin
      check_eq({tag, "_atm_quiet"}, n_act, 0);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      check_eq({tag, "_hold_status"}, 32'(bus.rsp_status), 32'(e_st));
      check_eq({tag, "_hold_balance"}, 32'(bus.rsp_balance), 32'(e_bal));
      check_eq({tag, "_hold_req_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
    check_eq({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check_eq({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check_eq({tag, "_rsp_status"}, 32'(bus.rsp_status), 32'(ST_OK));
    check_eq({tag, "_rsp_balance"}, 32'(bus.rsp_balance), 32'd0);
    check_eq({tag, "_atm_op"}, 32'(bus.atm_operation), 32'(OP_NOP));
    check_eq({tag, "_atm_acc"}, 32'(bus.atm_acc_num), 32'd0);
    check_eq({tag, "_atm_pin"}, 32'(bus.atm_pin), 32'd0);
    check_eq({tag, "_atm_amount"}, 32'(bus.atm_amount), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [2:0]  r_op;
    logic [3:0]  r_acc;
    logic [15:0] r_pin, r_amt;
    int          sel;

    for (int i = 0; i < 16; i++) begin
      atm_bal[i] = 16'd500; m_bal[i] = 16'd500; m_fail[i] = 0;
    end
    d_auth = 0; d_txn = 0; hang_auth = 0; hang_txn = 0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_acc = '0;
    bus.req_pin = '0; bus.req_amount = '0; bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_outputs("reset");

    run_txn("wd_ok",    OP_WITHDRAW, 4'd2,  pin_of(4'd2), 16'd100, 0, 0, 0, 0, 0);
    run_txn("wd_insuff", OP_WITHDRAW, 4'd3, pin_of(4'd3), 16'd600, 0, 0, 0, 0, 0);
    run_txn("bad_acc",  OP_BALANCE,  4'd12, pin_of(4'd12), 16'd0,  0, 0, 0, 0, 0);
    run_txn("bad_op",   3'd7,        4'd1,  pin_of(4'd1), 16'd5,   0, 0, 0, 0, 0);
    run_txn("bad_nop",  OP_NOP,      4'd1,  pin_of(4'd1), 16'd5,   0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      run_txn("pin_fail", OP_BALANCE, 4'd5, pin_of(4'd5) ^ 16'h0001, 16'd0, k, 0, 0, 0, 0);
    run_txn("locked",   OP_BALANCE,  4'd5,  pin_of(4'd5), 16'd0,   0, 0, 0, 0, 0);
    run_txn("other_acc", OP_DEPOSIT, 4'd6,  pin_of(4'd6), 16'd50,  0, 0, 0, 0, 0);
    run_txn("txn_hang", OP_BALANCE,  4'd7,  pin_of(4'd7), 16'd0,   0, 0, 0, 1, 5);
    run_txn("auth_hang", OP_WITHDRAW, 4'd8, pin_of(4'd8), 16'd10,  0, 0, 1, 0, 0);
    run_txn("auth_edge", OP_BALANCE, 4'd1,  pin_of(4'd1), 16'd0,  63, 0, 0, 0, 0);
    run_txn("auth_late", OP_BALANCE, 4'd1,  pin_of(4'd1), 16'd0,  64, 0, 0, 0, 0);
    run_txn("txn_edge", OP_DEPOSIT,  4'd9,  pin_of(4'd9), 16'd7,   1, 63, 0, 0, 0);

    // Reset while the ATM is mid-authentication
    d_auth = 0; d_txn = 0; hang_auth = 1; hang_txn = 0;
    bus.req_valid = 1'b1; bus.req_op = OP_WITHDRAW; bus.req_acc = 4'd6;
    bus.req_pin = pin_of(4'd6); bus.req_amount = 16'd20;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_eq("pre_reset_auth_op", 32'(bus.atm_operation), 32'(OP_AUTH));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    hang_auth = 0;
    for (int i = 0; i < 16; i++) m_fail[i] = 0;
    run_txn("unlocked", OP_BALANCE, 4'd5, pin_of(4'd5), 16'd0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      sel   = int'($urandom_range(0, 9));
      r_op  = (sel == 0) ? 3'($urandom) : 3'($urandom_range(2, 4));
      r_acc = (sel == 1) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      r_pin = ($urandom_range(0, 9) < 8) ? pin_of(r_acc) : 16'($urandom);
      r_amt = 16'($urandom_range(0, 700));
      run_txn("rand", r_op, r_acc, r_pin, r_amt,
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
              int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/atm_session_initiator.md
Name: atm_session_initiator

Overview:
- Host-side initiator for the ATM core's transaction interface: accepts one customer request on a valid/ready handshake and drives the ATM's operation/acc_num/pin/amount inputs through authenticate -> transact -> exit.
- Collects the ATM's state/balance response and returns one status+balance result to the host.
- Adds invalid-account filtering, a response timeout and a per-account PIN-failure lockout.

Parameters:
- NUM_ACCOUNTS, 10, valid account numbers are 0..NUM_ACCOUNTS-1
- TIMEOUT_CYCLES, 64, max cycles to wait for an ATM response per phase
- MAX_FAILS, 3, consecutive auth failures that lock an account

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  host request valid
- req_ready  out  1  high only in IDLE
- req_op  in  3  OP_BALANCE, OP_WITHDRAW or OP_DEPOSIT
- req_acc  in  4  account number
- req_pin  in  16  PIN
- req_amount  in  16  amount (ignored for OP_BALANCE)
- rsp_valid  out  1  result valid, held until rsp_ready
- rsp_ready  in  1  host accepts result
- rsp_status  out  3  ST_OK/ST_AUTH_FAIL/ST_INSUFF/ST_LOCKED/ST_BAD_ACC/ST_TIMEOUT
- rsp_balance  out  16  balance reported by the ATM, else 0
- atm_operation  out  3  to ATM operation
- atm_acc_num  out  4  to ATM acc_num
- atm_pin  out  16  to ATM pin
- atm_amount  out  16  to ATM amount
- atm_balance  in  16  from ATM balance
- atm_state  in  3  from ATM state

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset values: FSM=IDLE, atm_operation=OP_NOP, atm_acc_num/pin/amount=0, rsp_valid=0, rsp_status=ST_OK, rsp_balance=0, all fail counters=0, timer=0.
- Reset mid-transaction aborts it. No OP_EXIT is sent and no response is produced.
- Handshake:
  - A request is accepted on a cycle with req_valid && req_ready. Inputs are registered that cycle.
  - The host may change inputs after acceptance.
  - rsp_valid stays high with stable status/balance until rsp_ready. Dropping to IDLE happens on that same cycle.
  - req_ready rises the cycle after the response handshake (no same-cycle accept).
- FSM states:
  - IDLE: wait for handshake, then go to CHECK.
  - CHECK (1 cycle):
    - acc >= NUM_ACCOUNTS -> RESP with ST_BAD_ACC.
    - fail_cnt[acc] == MAX_FAILS -> RESP with ST_LOCKED.
    - req_op not one of the three legal ops -> RESP with ST_BAD_ACC.
    - Otherwise -> AUTH.
  - AUTH:
    - Drive OP_AUTH, acc, pin; clear timer on entry.
    - atm_state==A_AUTH_OK -> clear fail_cnt[acc], go to TXN.
    - A_AUTH_FAIL -> fail_cnt[acc]+1 (saturating at MAX_FAILS), go to EXIT with ST_AUTH_FAIL.
    - Timer reaching TIMEOUT_CYCLES-1 -> EXIT with ST_TIMEOUT.
  - TXN:
    - Drive the registered op and amount; clear timer on entry.
    - A_DONE -> capture atm_balance, ST_OK.
    - A_DENIED -> capture atm_balance, ST_INSUFF.
    - Timeout -> ST_TIMEOUT.
    - All three exits go to EXIT.
  - EXIT: drive OP_EXIT for exactly 1 cycle, then go to RESP.
  - RESP: rsp_valid=1, atm_operation=OP_NOP.
- atm_operation is OP_NOP in IDLE, CHECK and RESP.
- atm_* outputs are registered: a change on the state transition is visible the next cycle.
- atm_state is sampled only from the second cycle in AUTH/TXN, so the ATM's previous state is ignored.
- Latency: best case accept->rsp_valid = 1(CHECK)+2(AUTH)+2(TXN)+1(EXIT)+1 = 7 cycles. Bad-acc/locked = 2 cycles.
- Timer: 7-bit-or-wider counter that compares against TIMEOUT_CYCLES. Every ATM phase terminates.
- Fail counters: NUM_ACCOUNTS x 2 bits. A locked account stays locked until reset; no unlock path in this block.
- rsp_balance is 0 for ST_AUTH_FAIL, ST_LOCKED, ST_BAD_ACC and ST_TIMEOUT.
- Simultaneous timeout expiry and a valid atm_state response: the response wins.

Decomposition:
- Shared package (definitions.v):
  - Operation codes: OP_NOP=0, OP_AUTH=1, OP_BALANCE=2, OP_WITHDRAW=3, OP_DEPOSIT=4, OP_EXIT=5.
  - ATM state codes: A_IDLE=0, A_BUSY=1, A_AUTH_OK=2, A_AUTH_FAIL=3, A_DONE=4, A_DENIED=5.
  - rsp status codes: ST_OK=0, ST_AUTH_FAIL=1, ST_INSUFF=2, ST_LOCKED=3, ST_BAD_ACC=4, ST_TIMEOUT=5.
- One sub-module: atm_fail_tracker, holding the per-account saturating counters with inputs inc/clr/acc and output locked.

Test Plan:
- Reset, then withdraw acc=2, correct pin, amount=100; model ATM returns A_DONE with balance 400 -> rsp ST_OK, balance 400 at cycle 7; OP_EXIT seen for exactly 1 cycle.
- Withdraw acc=3, amount=600; ATM returns A_DENIED with balance 500 -> ST_INSUFF, balance 500.
- req_acc=12 -> ST_BAD_ACC 2 cycles after accept; atm_operation never leaves OP_NOP.
- Three wrong-PIN requests on acc=5 -> three ST_AUTH_FAIL; fourth request (correct pin) -> ST_LOCKED with no OP_AUTH driven; acc=6 still authenticates.
- ATM holds A_BUSY forever during TXN -> ST_TIMEOUT after TIMEOUT_CYCLES, then OP_EXIT, balance 0.
- Assert rst_n=0 during AUTH -> next cycle all outputs at reset values; hold rsp_ready=0 for 5 cycles -> rsp_valid/status stable and req_ready=0.
